seg_blank_sequencer: RTL and testbench
======================================

Name: seg_blank_sequencer

Overview:
- Generates the 3-bit currentState index of the blanked digit and feeds it to the anode driver stage of the 8-digit seven-segment display.
- Moves the blanked position automatically at a prescaled rate, or one step per debounced push of the step button.
- Supports rotate-up, rotate-down, ping-pong and hold patterns.

Parameters:
- TICK_DIV, 50_000_000: CLK cycles per auto-advance tick (0.5 s at 100 MHz). Must be ≥2.
- DEB_CYC, 1_000_000: cycles the synchronized button level must differ from the debounced level before it is accepted (10 ms). Must be ≥2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- RUN  in  1  level; 1 enables auto-advance ticks.
- MODE  in  2  pattern: 00 rotate up, 01 rotate down, 10 ping-pong, 11 hold.
- BTN_STEP  in  1  raw, asynchronous pushbutton; each accepted press gives one manual step.
- currentState  out  3  blanked digit index 0..7, to the anode driver.
- STEP  out  1  one-cycle pulse, high in the first cycle currentState shows a new value.
- PP_DIR  out  1  ping-pong direction: 0 up, 1 down.

Behaviour:
- Reset (RST=1 at a CLK edge): currentState=0, STEP=0, PP_DIR=0, prescaler=0, synchronizer flops=0, debounced level=0, debounce counter=0. RST has priority over every other input.
- Prescaler:
  - Counts 0..TICK_DIV-1 while RUN=1, then wraps to 0.
  - tick is asserted combinationally in the cycle where count==TICK_DIV-1 and RUN=1.
  - RUN=0 freezes the count; it is not cleared. Changing MODE does not affect the prescaler.
- Button path:
  - 2-flop synchronizer, then debounce.
  - Debounce: if the synced level differs from the debounced level, the counter increments; when the counter reaches DEB_CYC-1, the debounced level takes the synced value and the counter clears. If the levels are equal, the counter clears.
  - press is a one-cycle pulse on a 0→1 edge of the debounced level. Release generates nothing.
  - Manual steps are accepted regardless of RUN.
- Advance event: adv = tick OR press. tick and press in the same cycle give exactly one step.
- Next-state rules, applied at the edge ending an adv cycle:
  - MODE=00: s ← s+1 mod 8 (7→0).
  - MODE=01: s ← s−1 mod 8 (0→7).
  - MODE=10, PP_DIR=0: if s==7 then PP_DIR←1 and s←6; else s←s+1.
  - MODE=10, PP_DIR=1: if s==0 then PP_DIR←0 and s←1; else s←s−1.
  - MODE=11: no change; STEP stays 0. The prescaler keeps running and events are discarded.
- Latency and STEP:
  - currentState and STEP are registered; both update at the same edge.
  - STEP=1 for exactly the one cycle after each effective advance. There is no STEP in hold mode.
- Mode interaction:
  - PP_DIR is held while MODE≠10.
  - Re-entering ping-pong continues in the retained direction from the current s.
  - MODE is sampled in the adv cycle; a MODE change in the same cycle uses the new value.
- Reset mid-operation: a pending debounce or partial prescale count is discarded. A button still held after reset release is seen as a fresh press once it has been stable for DEB_CYC cycles.
- Press-to-step latency: 2 (sync) + DEB_CYC (debounce) + 1 (press pulse) + 1 (state register) cycles from the raw level change.

Decomposition:
- Shared package seg_pkg:
  - MODE encodings as localparams MODE_UP, MODE_DN, MODE_PP, MODE_HOLD.
  - NUM_DIGITS=8 and DIGIT_IDX_W=3, also used by the anode driver.
- One sub-module, btn_debounce, parameterised by DEB_CYC: synchronizer, debounce counter and rising-edge pulse. Reused for future buttons.
- The prescaler and the next-state logic stay in the top module.

Test Plan (TICK_DIV=4, DEB_CYC=3):
- Reset then RUN=1, MODE=00 for 40 cycles → currentState goes 0,1,…,7,0,1 with one change every 4 cycles; STEP pulses once per change.
- MODE=01 from s=0, RUN=1 → first tick gives s=7 then 6; with RUN=0 mid-count for 10 cycles then RUN=1 → remaining count resumes, with no early or extra tick.
- MODE=10 from s=5, RUN=1 → sequence 6,7,6,5,…,0,1; PP_DIR goes 0→1 at the 7→6 step and 1→0 at the 0→1 step.
- RUN=0, MODE=00:
  - BTN_STEP high for 2 cycles → no step.
  - Held high for 10 cycles → exactly one step, 2+3+1+1 cycles after the edge.
  - Release → no step.
- Press pulse aligned with the tick cycle → single step (s 3→4), not two. MODE=11 with ticks and presses → currentState constant, STEP never asserted.
- RST asserted mid-count with s=5, PP_DIR=1 → the next cycle shows currentState=0, PP_DIR=0, STEP=0; the first tick arrives 4 cycles after RST deasserts.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blanking path.
// Mode encodings and digit index sizing are also used by the anode driver.
package seg_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int DIGIT_IDX_W = 3;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debounce, and a
// registered one-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic srst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          deb_reg;
  logic          deb_prev_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      deb_reg      <= 1'b0;
      deb_prev_reg <= 1'b0;
      press_reg    <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= btn_raw;
      sync2_reg    <= sync1_reg;
      deb_prev_reg <= deb_reg;
      press_reg    <= deb_reg & ~deb_prev_reg;
      // Any return to the debounced level restarts the stability window.
      if (sync2_reg != deb_reg) begin
        if (cnt_reg == CW'(DEB_CYC - 1)) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/seg_blank_sequencer.sv
// Selects which of the display digits is blanked; advances on a prescaled
// tick or a debounced button press using rotate/ping-pong/hold patterns.
module seg_blank_sequencer
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DEB_CYC  = 1_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RUN,
  input  logic [1:0]             MODE,
  input  logic                   BTN_STEP,
  output logic [DIGIT_IDX_W-1:0] currentState,
  output logic                   STEP,
  output logic                   PP_DIR
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIGIT_IDX_W-1:0] MAX_IDX = DIGIT_IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_IDX_W-1:0] ONE     = DIGIT_IDX_W'(1);

  logic [PW-1:0]          presc_reg;
  logic                   tick;
  logic                   press;
  logic                   adv;
  logic [DIGIT_IDX_W-1:0] state_reg, state_next;
  logic                   dir_reg, dir_next;
  logic                   step_reg, step_next;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
    .clk     (CLK),
    .srst    (RST),
    .btn_raw (BTN_STEP),
    .press   (press)
  );

  assign tick = RUN && (presc_reg == PW'(TICK_DIV - 1));
  assign adv  = tick | press;

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg <= '0;
    end else if (RUN) begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    step_next  = 1'b0;
    if (adv) begin
      case (MODE)
        MODE_UP: begin
          state_next = state_reg + ONE;
          step_next  = 1'b1;
        end
        MODE_DN: begin
          state_next = state_reg - ONE;
          step_next  = 1'b1;
        end
        MODE_PP: begin
          step_next = 1'b1;
          // Bounce at the ends so neither end digit is shown twice in a row.
          if (!dir_reg) begin
            if (state_reg == MAX_IDX) begin
              dir_next   = 1'b1;
              state_next = state_reg - ONE;
            end else begin
              state_next = state_reg + ONE;
            end
          end else begin
            if (state_reg == '0) begin
              dir_next   = 1'b0;
              state_next = ONE;
            end else begin
              state_next = state_reg - ONE;
            end
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= '0;
      dir_reg   <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
    end
  end

  assign currentState = state_reg;
  assign STEP         = step_reg;
  assign PP_DIR       = dir_reg;

endmodule

// File: tb/tb_seg_blank_sequencer.sv
// Directed bench for seg_blank_sequencer with TICK_DIV=4, DEB_CYC=3.
// Each table row holds inputs for N cycles, then checks state, STEP, PP_DIR and step count.
module tb_seg_blank_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] mode;
  logic       btn;
  logic [2:0] cur_state;
  logic       step;
  logic       pp_dir;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       run;
    logic [1:0] mode;
    logic       btn;
    int         ncyc;
    logic [2:0] exp_state;
    int         exp_steps;
    logic       exp_step;
    logic       exp_dir;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seg_blank_sequencer #(.TICK_DIV(4), .DEB_CYC(3)) dut (
    .CLK          (clk),
    .RST          (rst),
    .RUN          (run),
    .MODE         (mode),
    .BTN_STEP     (btn),
    .currentState (cur_state),
    .STEP         (step),
    .PP_DIR       (pp_dir)
  );

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nsteps;
    rst = 1'b1; run = 1'b0; mode = 2'b00; btn = 1'b0;

    //               run mode  btn  n   state steps step dir
    vecs.push_back('{1'b1, 2'b00, 1'b0,  3, 3'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0,  1, 3'd1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 36, 3'd2, 9, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 24, 3'd0, 6, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0,  4, 3'd7, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0,  4, 3'd6, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0,  2, 3'd6, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 10, 3'd6, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0,  1, 3'd6, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0,  1, 3'd5, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  4, 3'd6, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  4, 3'd7, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  4, 3'd6, 1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 24, 3'd0, 6, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  4, 3'd1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1,  2, 3'd1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 10, 3'd1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1,  6, 3'd1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1,  1, 3'd2, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1,  3, 3'd2, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 10, 3'd2, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0,  1, 3'd2, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b1,  7, 3'd4, 2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 10, 3'd4, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 1'b1, 12, 3'd4, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 10, 3'd4, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  2, 3'd5, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 16, 3'd5, 4, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 1'b0,  2, 3'd5, 0, 1'b0, 1'b1});

    // Reset state
    tick_clk();
    tick_clk();
    check("reset_state", int'(cur_state), 0);
    check("reset_step", int'(step), 0);
    check("reset_ppdir", int'(pp_dir), 0);
    $display("[TB] reset: state=%0d step=%0d pp_dir=%0d", cur_state, step, pp_dir);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      run = vecs[r].run; mode = vecs[r].mode; btn = vecs[r].btn;
      nsteps = 0;
      for (int c = 0; c < vecs[r].ncyc; c++) begin
        tick_clk();
        if (step) nsteps++;
      end
      check($sformatf("row%0d_state", r), int'(cur_state), int'(vecs[r].exp_state));
      check($sformatf("row%0d_steps", r), nsteps, vecs[r].exp_steps);
      check($sformatf("row%0d_step", r), int'(step), int'(vecs[r].exp_step));
      check($sformatf("row%0d_ppdir", r), int'(pp_dir), int'(vecs[r].exp_dir));
      $display("[TB] row %0d: run=%0d mode=%0d btn=%0d n=%0d -> state=%0d steps=%0d pp_dir=%0d",
               r, run, mode, btn, vecs[r].ncyc, cur_state, nsteps, pp_dir);
    end

    // Mid-count reset with s=5, PP_DIR=1, then first tick 4 cycles later
    rst = 1'b1;
    tick_clk();
    check("midrst_state", int'(cur_state), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_ppdir", int'(pp_dir), 0);
    $display("[TB] mid reset: state=%0d step=%0d pp_dir=%0d", cur_state, step, pp_dir);
    rst = 1'b0; run = 1'b1; mode = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      tick_clk();
      check($sformatf("postrst_c%0d_state", k), int'(cur_state), (k == 4) ? 1 : 0);
      check($sformatf("postrst_c%0d_step", k), int'(step), (k == 4) ? 1 : 0);
      $display("[TB] post reset cycle %0d: state=%0d step=%0d", k, cur_state, step);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
